seq_divider: RTL

- Multi-cycle 16-bit unsigned divider; takes over the DIV opcode path from the single-cycle ALU.
- Produces the integer quotient and remainder by restoring division, one bit per clock.
- In fractional mode it also produces a 0.16 fixed-point fraction of remainder/divisor.
- Sits beside the ALU in the execute stage; the controller stalls on Busy and captures results on Done.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 27 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider and its restoring step.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // ALU opcode that the execute stage routes to the sequential divider.
    localparam logic [2:0] DIV_OP = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        INT,
        FRAC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift a bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Extra top bit keeps the shifted remainder from wrapping when the
    // divisor uses the MSB; the difference always fits WIDTH bits.
    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted[WIDTH-1:0] - divisor;
        q_bit    = (shifted >= {1'b0, divisor});
        next_rem = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: integer quotient/remainder, optionally
// followed by a 0.WIDTH fixed-point fraction of remainder/divisor.
//
//  state | meaning
//  IDLE  | waiting for Start; results held
//  INT   | WIDTH integer quotient iterations
//  FRAC  | WIDTH fraction iterations (Frac=1 only)
//  DONE  | one-cycle Done pulse; results valid
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Frac,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic             Zero
);

    div_state_t       state, next_state;
    logic [WIDTH-1:0] dividend, divisor, rem, quot, frac_bits;
    logic [CNT_W-1:0] cnt;
    logic             frac_mode;
    logic             last_iter;
    logic             step_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign step_in   = (state == INT) ? dividend[WIDTH-1] : 1'b0;
    assign Zero      = (Out1 == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .in_bit   (step_in),
        .divisor  (divisor),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode and status outputs.
    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: if (Start) next_state = (InputB == '0) ? DONE : INT;
            INT: begin
                Busy = 1'b1;
                if (last_iter) next_state = frac_mode ? FRAC : DONE;
            end
            FRAC: begin
                Busy = 1'b1;
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            quot      <= '0;
            frac_bits <= '0;
            cnt       <= '0;
            frac_mode <= 1'b0;
            Out1      <= '0;
            Out2      <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    DivZero <= (InputB == '0);
                    if (InputB == '0) begin
                        Out1 <= '1;
                        Out2 <= Frac ? '0 : InputA;
                    end else begin
                        dividend  <= InputA;
                        divisor   <= InputB;
                        frac_mode <= Frac;
                        rem       <= '0;
                        quot      <= '0;
                        frac_bits <= '0;
                        cnt       <= '0;
                    end
                end
                INT: begin
                    rem      <= step_rem;
                    quot     <= {quot[WIDTH-2:0], step_q};
                    dividend <= dividend << 1;
                    cnt      <= last_iter ? '0 : cnt + CNT_W'(1);
                    if (last_iter && !frac_mode) begin
                        Out1 <= {quot[WIDTH-2:0], step_q};
                        Out2 <= step_rem;
                    end
                end
                FRAC: begin
                    rem       <= step_rem;
                    frac_bits <= {frac_bits[WIDTH-2:0], step_q};
                    cnt       <= last_iter ? '0 : cnt + CNT_W'(1);
                    if (last_iter) begin
                        Out1 <= quot;
                        Out2 <= {frac_bits[WIDTH-2:0], step_q};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
